// File: rtl/frame_loader_pkg.sv
// Shared constants and types for the frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_loader_pkg;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [7:0] BUSY   = 8'h42;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PIX_HI = 2'd1,
    PIX_LO = 2'd2,
    CHK    = 2'd3
  } state_e;

  // Increment an 8-bit error counter, sticking at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank pixel store, one write port and one synchronous read port.
// Latency: read data 1 cycle after address; write lands on the clock edge.
// Backpressure: none, both ports accept every cycle.
module frame_bank_ram #(
  parameter int AW = 5,
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  // Address is {bank, index}; index slots at or above W*H are never written.
  localparam int DEPTH = 2 ** (AW + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port: store one pixel when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read, contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_loader.sv
// Byte-stream image receiver with per-block XOR check, ACK/NAK replies and a double-buffered store.
// Latency: replies and frame_done 1 cycle after the triggering rx byte; read data 1 cycle after address.
// Backpressure: none on rx; a header arriving while a frame awaits display is answered BUSY and dropped.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int W           = 5,
  parameter int H           = 4,
  parameter int PIX_W       = 12,
  parameter int BLOCK_PIX   = 4,
  parameter int TIMEOUT_CYC = 5_000_000,
  localparam int AW         = $clog2(W * H)
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_frame_start,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [PIX_W-1:0] o_rd_data,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  output logic             o_receiving,
  output logic             o_pending,
  output logic             o_front_bank,
  output logic             o_frame_done,
  output logic [7:0]       o_err_cnt
);

  // Pointer is one bit wider than the index so it can hold W*H itself.
  localparam int PW = AW + 1;
  localparam int MW = PIX_W - 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] NPIX_P   = PW'(W * H);
  localparam logic [PW-1:0] BLK_P    = PW'(BLOCK_PIX);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   blk_q, blk_d;
  logic [7:0]      chk_q, chk_d;
  logic [MW-1:0]   msb_q, msb_d;
  logic            pend_q, pend_d;
  logic            front_q, front_d;
  logic [7:0]      err_q, err_d;
  logic            tx_vld_q, tx_vld_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            done_q, done_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rd_ok_q, rd_ok_d;

  logic            wr_en;
  logic [PW-1:0]   ptr_inc;
  logic [PIX_W-1:0] ram_rdata;

  // Next-state logic: FSM, checksum, pointers, timeout and bank swap.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    blk_d    = blk_q;
    chk_d    = chk_q;
    msb_d    = msb_q;
    pend_d   = pend_q;
    front_d  = front_q;
    err_d    = err_q;
    tx_vld_d = 1'b0;
    tx_dat_d = tx_dat_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;
    wr_en    = 1'b0;
    ptr_inc  = ptr_q + PW'(1);

    // Swap only on a strobe that sees an already-registered pending frame.
    if (i_frame_start && pend_q) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end

    // Idle-gap counter; a received byte always restarts it.
    if (state_q == IDLE || i_rx_done || tmo_q == TMO_LAST) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (i_rx_done) begin
      unique case (state_q)
        IDLE: begin
          if (i_rx_data == HEADER) begin
            if (pend_q) begin
              tx_vld_d = 1'b1;
              tx_dat_d = BUSY;
            end else begin
              state_d = PIX_HI;
              ptr_d   = '0;
              blk_d   = '0;
              chk_d   = '0;
            end
          end
        end
        PIX_HI: begin
          msb_d   = i_rx_data[MW-1:0];
          chk_d   = chk_q ^ i_rx_data;
          state_d = PIX_LO;
        end
        PIX_LO: begin
          wr_en = 1'b1;
          ptr_d = ptr_inc;
          chk_d = chk_q ^ i_rx_data;
          if ((ptr_inc - blk_q) == BLK_P || ptr_inc == NPIX_P) begin
            state_d = CHK;
          end else begin
            state_d = PIX_HI;
          end
        end
        CHK: begin
          tx_vld_d = 1'b1;
          chk_d    = '0;
          if (i_rx_data == chk_q) begin
            tx_dat_d = ACK;
            blk_d    = ptr_q;
            if (ptr_q == NPIX_P) begin
              done_d  = 1'b1;
              pend_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PIX_HI;
            end
          end else begin
            tx_dat_d = NAK;
            ptr_d    = blk_q;
            err_d    = sat_inc(err_q);
            state_d  = PIX_HI;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      // Sender went quiet: abandon the frame silently.
      state_d = IDLE;
      err_d   = sat_inc(err_q);
    end

    rd_ok_d = ({1'b0, i_rd_addr} < NPIX_P);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      blk_q    <= '0;
      chk_q    <= '0;
      msb_q    <= '0;
      pend_q   <= 1'b0;
      front_q  <= 1'b0;
      err_q    <= '0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= '0;
      done_q   <= 1'b0;
      tmo_q    <= '0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      blk_q    <= blk_d;
      chk_q    <= chk_d;
      msb_q    <= msb_d;
      pend_q   <= pend_d;
      front_q  <= front_d;
      err_q    <= err_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      rd_ok_q  <= rd_ok_d;
    end
  end

  // Writes always target the back bank; reads always the front bank.
  frame_bank_ram #(
    .AW (AW),
    .DW (PIX_W)
  ) u_ram (
    .i_clk   (i_clk_sys),
    .i_we    (wr_en),
    .i_waddr ({~front_q, ptr_q[AW-1:0]}),
    .i_wdata ({msb_q, i_rx_data}),
    .i_raddr ({front_q, i_rd_addr}),
    .o_rdata (ram_rdata)
  );

  assign o_rd_data    = rd_ok_q ? ram_rdata : '0;
  assign o_tx_data    = tx_dat_q;
  assign o_tx_valid   = tx_vld_q;
  assign o_receiving  = (state_q != IDLE);
  assign o_pending    = pend_q;
  assign o_front_bank = front_q;
  assign o_frame_done = done_q;
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: expected reply bytes queued at stimulus, popped on o_tx_valid.
// Latency: replies checked the cycle after each triggering byte.
// Backpressure: n/a.
module tb_frame_loader;
  import frame_loader_pkg::*;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int PIX_W = 12;
  localparam int BLK   = 4;
  localparam int TMO   = 64;
  localparam int NPIX  = W * H;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic             frame_start;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             receiving;
  logic             pending;
  logic             front_bank;
  logic             frame_done;
  logic [7:0]       err_cnt;

  int               n_vec = 0;
  int               n_bad = 0;
  int               fd_cnt = 0;
  int               exp_err = 0;
  logic             exp_front = 1'b0;
  logic [7:0]       exp_q[$];
  logic [PIX_W-1:0] model [2][32];

  always #5 clk = ~clk;

  frame_loader #(
    .W           (W),
    .H           (H),
    .PIX_W       (PIX_W),
    .BLOCK_PIX   (BLK),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk_sys     (clk),
    .i_rst_n       (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_done     (rx_done),
    .i_frame_start (frame_start),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .o_receiving   (receiving),
    .o_pending     (pending),
    .o_front_bank  (front_bank),
    .o_frame_done  (frame_done),
    .o_err_cnt     (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reply monitor: every reply must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      check("done_with_ack", 32'({tx_valid, tx_data}), 32'({1'b1, ACK}));
    end
    if (tx_valid) begin
      check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic fs = 1'b0);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1; frame_start = fs;
    @(posedge clk); #1;
    rx_done = 1'b0; frame_start = 1'b0;
  endtask

  task automatic send_block(input int start, input logic [7:0] seed, input logic bad, input logic fs_last);
    logic [7:0] c;
    int n;
    c = 8'h00;
    n = (NPIX - start < BLK) ? NPIX - start : BLK;
    for (int k = 0; k < n; k++) begin
      logic [7:0] hi, lo;
      hi = 8'(start + k) ^ seed;
      lo = 8'(32 + start + k) ^ seed;
      send_byte(hi);
      send_byte(lo);
      c = c ^ hi ^ lo;
      if (!bad) model[~exp_front][start + k] = {hi[3:0], lo};
    end
    exp_q.push_back(bad ? NAK : ACK);
    send_byte(bad ? ~c : c, fs_last);
    if (bad) begin
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      check("err_after_nak", 32'(err_cnt), 32'(exp_err));
      check("rx_after_nak", 32'(receiving), 32'd1);
    end
  endtask

  task automatic send_frame(input logic [7:0] seed, input int bad_blk, input logic fs_on_last);
    send_byte(HEADER);
    for (int s = 0; s < NPIX; s += BLK) begin
      if (s / BLK == bad_blk) send_block(s, seed, 1'b1, 1'b0);
      send_block(s, seed, 1'b0, fs_on_last && (s + BLK >= NPIX));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic swap();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    exp_front = ~exp_front;
    check("swap_front", 32'(front_bank), 32'(exp_front));
    check("swap_pending", 32'(pending), 32'd0);
  endtask

  task automatic verify_image(input string tag);
    for (int i = 0; i < NPIX; i++) begin
      rd_addr = AW'(i);
      @(posedge clk); #1;
      check(tag, 32'(rd_data), 32'(model[exp_front][i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; frame_start = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_front", 32'(front_bank), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_receiving", 32'(receiving), 32'd0);
    rst_n = 1'b1;

    // Clean frame.
    send_frame(8'h00, -1, 1'b0);
    check("f1_done_cnt", 32'(fd_cnt), 32'd1);
    check("f1_pending", 32'(pending), 32'd1);
    check("f1_front", 32'(front_bank), 32'd0);
    check("f1_idle", 32'(receiving), 32'd0);
    check("f1_q_empty", 32'(exp_q.size()), 32'd0);
    swap();
    verify_image("f1_pix");

    // NAK on the second block, retransmit, frame_start coincident with final ACK.
    send_frame(8'hA0, 1, 1'b1);
    check("f2_done_cnt", 32'(fd_cnt), 32'd2);
    check("f2_no_swap", 32'(front_bank), 32'(exp_front));
    check("f2_pending", 32'(pending), 32'd1);
    check("f2_err", 32'(err_cnt), 32'd1);
    swap();
    verify_image("f2_pix");

    // Stall three bytes into a frame.
    send_byte(HEADER);
    send_byte(8'h01);
    send_byte(8'h22);
    repeat (TMO / 2) @(posedge clk);
    #1;
    check("tmo_still_rx", 32'(receiving), 32'd1);
    repeat (TMO) @(posedge clk);
    #1;
    exp_err++;
    check("tmo_idle", 32'(receiving), 32'd0);
    check("tmo_err", 32'(err_cnt), 32'(exp_err));

    // Fresh frame after the timeout must restart at pixel 0.
    send_frame(8'h5A, -1, 1'b0);
    check("f3_done_cnt", 32'(fd_cnt), 32'd3);
    check("f3_pending", 32'(pending), 32'd1);

    // Header while a frame is pending: BUSY, stay idle, back bank untouched.
    exp_q.push_back(BUSY);
    send_byte(HEADER);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (2) @(posedge clk);
    #1;
    check("busy_idle", 32'(receiving), 32'd0);
    check("busy_pending", 32'(pending), 32'd1);
    check("busy_q_empty", 32'(exp_q.size()), 32'd0);
    swap();
    verify_image("f3_pix");

    // Out-of-range reads.
    rd_addr = AW'(20);
    @(posedge clk); #1;
    check("rd_oob_20", 32'(rd_data), 32'd0);
    rd_addr = AW'(31);
    @(posedge clk); #1;
    check("rd_oob_31", 32'(rd_data), 32'd0);

    // Drive the error counter into saturation with repeated NAKs.
    send_byte(HEADER);
    for (int r = 0; r < 256; r++) send_block(0, 8'h33, 1'b1, 1'b0);
    check("err_sat", 32'(err_cnt), 32'd255);

    // Reset mid-block.
    send_byte(8'h07);
    send_byte(8'h08);
    rd_addr = AW'(3);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_q_empty", 32'(exp_q.size()), 32'd0);
    check("pre_rst_front", 32'(front_bank), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_front", 32'(front_bank), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_receiving", 32'(receiving), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(receiving), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
